// File: rtl/sort_pkg.sv
// Shared definitions for the sort engine: FSM state encoding and parameter defaults.
package sort_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } sort_state_t;

    localparam int DEF_ELEMENT_NUM = 8;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DESCEND     = 1;
    localparam int DEF_SIGNED      = 1;

endpackage

// File: rtl/sort_lsb_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit, any-bit-set and exactly-one-bit-set flags.
module sort_lsb_enc
    import sort_pkg::*;
#(
    parameter  int ELEMENT_NUM = DEF_ELEMENT_NUM,
    localparam int AW          = $clog2(ELEMENT_NUM)
) (
    input  logic [ELEMENT_NUM-1:0] vec,
    output logic [AW-1:0]          idx,
    output logic                   any,
    output logic                   one
);

    logic [ELEMENT_NUM-1:0] rest_s;

    // Scan from the top down so the last hit written is the lowest set index.
    always_comb begin
        idx = {AW{1'b0}};
        for (int i = ELEMENT_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = AW'(i);
            end else begin
                idx = idx;
            end
        end
    end

    // Clearing the lowest set bit leaves nothing exactly when a single bit was set.
    always_comb begin
        rest_s = vec & (vec - {{(ELEMENT_NUM-1){1'b0}}, 1'b1});
        any    = |vec;
        one    = (|vec) && (rest_s == {ELEMENT_NUM{1'b0}});
    end

endmodule

// File: rtl/sort_engine_param.sv
// Batch sort engine: emits the valid elements of a batch in sorted order, one
// equal-value group per filter evaluation, using a comparison-free bit-serial filter.
module sort_engine_param
    import sort_pkg::*;
#(
    parameter  int ELEMENT_NUM = DEF_ELEMENT_NUM,
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int DESCEND     = DEF_DESCEND,
    parameter  int SIGNED      = DEF_SIGNED,
    localparam int AW          = $clog2(ELEMENT_NUM),
    localparam int CW          = $clog2(ELEMENT_NUM + 1)
) (
    input  logic                            clk_mj,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ELEMENT_NUM*DATA_WIDTH-1:0] in_data,
    input  logic [CW-1:0]                   in_count,
    input  logic                            abort,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [AW-1:0]                   out_addr,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_group_end,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);

    sort_state_t                                state_r;
    logic [ELEMENT_NUM-1:0][DATA_WIDTH-1:0]     data_r;
    logic [ELEMENT_NUM-1:0]                     evt_r;
    logic [ELEMENT_NUM-1:0]                     fo_r;

    logic [CW-1:0]          count_s;
    logic [ELEMENT_NUM-1:0] evt_load_s;
    logic [ELEMENT_NUM-1:0] cand_s;
    logic [ELEMENT_NUM-1:0] sel_s;
    logic                   key_bit_s;
    logic [ELEMENT_NUM-1:0] fo_bit_s;
    logic [AW-1:0]          fo_idx_s;
    logic                   fo_any_s;
    logic                   fo_one_s;
    logic [AW-1:0]          evt_idx_unused_s;
    logic                   evt_any_s;
    logic                   evt_one_s;
    logic                   emit_s;

    sort_lsb_enc #(.ELEMENT_NUM(ELEMENT_NUM)) u_fo_enc (
        .vec (fo_r),
        .idx (fo_idx_s),
        .any (fo_any_s),
        .one (fo_one_s)
    );

    sort_lsb_enc #(.ELEMENT_NUM(ELEMENT_NUM)) u_evt_enc (
        .vec (evt_r),
        .idx (evt_idx_unused_s),
        .any (evt_any_s),
        .one (evt_one_s)
    );

    // Clamp the offered count and expand it into the per-element valid mask.
    always_comb begin
        if (in_count > CW'(ELEMENT_NUM)) begin
            count_s = CW'(ELEMENT_NUM);
        end else begin
            count_s = in_count;
        end
        for (int i = 0; i < ELEMENT_NUM; i++) begin
            evt_load_s[i] = (CW'(i) < count_s);
        end
    end

    // Bit-serial filter: keep narrowing the candidate set while some candidate has the preferred bit.
    always_comb begin
        cand_s    = evt_r;
        sel_s     = {ELEMENT_NUM{1'b0}};
        key_bit_s = 1'b0;
        for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
            for (int i = 0; i < ELEMENT_NUM; i++) begin
                if ((SIGNED != 0) && (b == DATA_WIDTH - 1)) begin
                    key_bit_s = ~data_r[i][b];
                end else begin
                    key_bit_s = data_r[i][b];
                end
                if (DESCEND != 0) begin
                    sel_s[i] = cand_s[i] & key_bit_s;
                end else begin
                    sel_s[i] = cand_s[i] & ~key_bit_s;
                end
            end
            if (sel_s != {ELEMENT_NUM{1'b0}}) begin
                cand_s = sel_s;
            end else begin
                cand_s = cand_s;
            end
        end
    end

    // One-hot mask of the element currently presented.
    always_comb begin
        fo_bit_s = {{(ELEMENT_NUM-1){1'b0}}, 1'b1} << fo_idx_s;
    end

    // Main FSM: abort and reset dominate; the filter result is captured in EVAL.
    always_ff @(posedge clk_mj) begin
        if (rst) begin
            state_r <= ST_IDLE;
            data_r  <= {(ELEMENT_NUM*DATA_WIDTH){1'b0}};
            evt_r   <= {ELEMENT_NUM{1'b0}};
            fo_r    <= {ELEMENT_NUM{1'b0}};
        end else if (abort && (state_r != ST_IDLE)) begin
            state_r <= ST_IDLE;
            evt_r   <= {ELEMENT_NUM{1'b0}};
            fo_r    <= {ELEMENT_NUM{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_r <= in_data;
                        evt_r  <= evt_load_s;
                        fo_r   <= {ELEMENT_NUM{1'b0}};
                        if (count_s == {CW{1'b0}}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_EVAL;
                        end
                    end
                end
                ST_EVAL: begin
                    fo_r <= cand_s;
                    if (evt_any_s) begin
                        state_r <= ST_EMIT;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        fo_r  <= fo_r & ~fo_bit_s;
                        evt_r <= evt_r & ~fo_bit_s;
                        // The emitted bit lies in both masks, so a single set bit means it empties.
                        if (evt_one_s) begin
                            state_r <= ST_DONE;
                        end else if (fo_one_s) begin
                            state_r <= ST_EVAL;
                        end else begin
                            state_r <= ST_EMIT;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        emit_s        = (state_r == ST_EMIT) && fo_any_s;
        out_valid     = emit_s;
        out_addr      = emit_s ? fo_idx_s : {AW{1'b0}};
        out_data      = emit_s ? data_r[fo_idx_s] : {DATA_WIDTH{1'b0}};
        out_group_end = emit_s & fo_one_s;
        out_last      = emit_s & evt_one_s;
        in_ready      = (state_r == ST_IDLE);
        busy          = (state_r != ST_IDLE);
        done          = (state_r == ST_DONE);
    end

endmodule

// File: tb/tb_sort_engine_param.sv
// Bench for sort_engine_param: two instances (signed/descending and unsigned/ascending)
// share stimulus; emitted sequences are compared against a selection-sort reference.
module tb_sort_engine_param;

    localparam int N = 4;
    localparam int W = 4;

    logic        clk_mj = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        abort;
    logic        out_ready;
    logic [15:0] in_data;
    logic [2:0]  in_count;

    logic        in_ready [2];
    logic        ov       [2];
    logic [1:0]  oa       [2];
    logic [3:0]  od       [2];
    logic        oge      [2];
    logic        olast    [2];
    logic        obusy    [2];
    logic        odone    [2];

    int tests = 0;
    int fails = 0;

    int got_addr [2][8];
    int got_data [2][8];
    int got_ge   [2][8];
    int got_last [2][8];
    int got_n    [2];
    int exp_addr [2][4];
    int exp_data [2][4];
    int exp_ge   [2][4];
    int exp_last [2][4];

    always #5 clk_mj = ~clk_mj;

    sort_engine_param #(.ELEMENT_NUM(N), .DATA_WIDTH(W), .DESCEND(1), .SIGNED(1)) dut_ds (
        .clk_mj(clk_mj), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_count(in_count), .abort(abort), .out_valid(ov[0]),
        .out_ready(out_ready), .out_addr(oa[0]), .out_data(od[0]), .out_group_end(oge[0]),
        .out_last(olast[0]), .busy(obusy[0]), .done(odone[0])
    );

    sort_engine_param #(.ELEMENT_NUM(N), .DATA_WIDTH(W), .DESCEND(0), .SIGNED(0)) dut_au (
        .clk_mj(clk_mj), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_count(in_count), .abort(abort), .out_valid(ov[1]),
        .out_ready(out_ready), .out_addr(oa[1]), .out_data(od[1]), .out_group_end(oge[1]),
        .out_last(olast[1]), .busy(obusy[1]), .done(odone[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: repeatedly pick the best remaining element; ties keep the lower index.
    task automatic model(input int dd, input logic [15:0] d, input int cnt, output int n, output int groups);
        bit desc;
        bit sgn;
        bit used [4];
        int best;
        int kb;
        int ki;
        desc   = (dd == 0);
        sgn    = (dd == 0);
        n      = (cnt > N) ? N : cnt;
        groups = 0;
        for (int i = 0; i < 4; i++) used[i] = 1'b0;
        for (int p = 0; p < n; p++) begin
            best = -1;
            kb   = 0;
            for (int i = 0; i < n; i++) begin
                int v;
                v  = int'(d[i*4 +: 4]);
                ki = (sgn && v >= 8) ? v - 16 : v;
                if (!used[i]) begin
                    if (best < 0 || (desc ? (ki > kb) : (ki < kb))) begin
                        best = i;
                        kb   = ki;
                    end
                end
            end
            used[best]     = 1'b1;
            exp_addr[dd][p] = best;
            exp_data[dd][p] = int'(d[best*4 +: 4]);
        end
        for (int p = 0; p < n; p++) begin
            exp_last[dd][p] = (p == n - 1) ? 1 : 0;
            exp_ge[dd][p]   = (p == n - 1 || exp_data[dd][p] != exp_data[dd][p+1]) ? 1 : 0;
            groups += exp_ge[dd][p];
        end
    endtask

    // mode 0: always ready, 1: 3-cycle stall from stall_start, 2: random ready.
    task automatic run_batch(input string name, input logic [15:0] d, input int cnt,
                             input int mode, input int stall_start);
        int n [2];
        int g [2];
        int done_k [2];
        int first_k [2];
        bit held [2];
        logic [1:0] pa [2];
        logic [3:0] pd [2];
        logic pg [2];
        logic pl [2];
        @(negedge clk_mj);
        check({name, ".ready0"}, in_ready[0], 1);
        check({name, ".ready1"}, in_ready[1], 1);
        in_valid = 1'b1;
        in_data  = d;
        in_count = cnt[2:0];
        for (int dd = 0; dd < 2; dd++) begin
            model(dd, d, cnt, n[dd], g[dd]);
            got_n[dd] = 0; done_k[dd] = -1; first_k[dd] = -1; held[dd] = 1'b0;
        end
        @(posedge clk_mj);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_mj);
            in_valid = 1'b0;
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = !(k >= stall_start && k < stall_start + 3);
            else out_ready = 1'($urandom_range(0, 1));
            for (int dd = 0; dd < 2; dd++) begin
                if (held[dd]) begin
                    check({name, ".hold_valid"}, ov[dd], 1);
                    check({name, ".hold_addr"}, oa[dd], pa[dd]);
                    check({name, ".hold_data"}, od[dd], pd[dd]);
                    check({name, ".hold_flags"}, {oge[dd], olast[dd]}, {pg[dd], pl[dd]});
                end
                held[dd] = 1'b0;
                if (ov[dd] === 1'b1) begin
                    if (first_k[dd] < 0) first_k[dd] = k;
                    if (out_ready) begin
                        if (got_n[dd] < 8) begin
                            got_addr[dd][got_n[dd]] = int'(oa[dd]);
                            got_data[dd][got_n[dd]] = int'(od[dd]);
                            got_ge[dd][got_n[dd]]   = int'(oge[dd]);
                            got_last[dd][got_n[dd]] = int'(olast[dd]);
                        end
                        got_n[dd]++;
                    end else begin
                        held[dd] = 1'b1;
                        pa[dd] = oa[dd]; pd[dd] = od[dd]; pg[dd] = oge[dd]; pl[dd] = olast[dd];
                    end
                end
                if (odone[dd] === 1'b1) begin
                    if (done_k[dd] >= 0) check({name, ".done_once"}, 32'(k), 32'(done_k[dd]));
                    done_k[dd] = k;
                end
            end
            if (done_k[0] >= 0 && done_k[1] >= 0) break;
        end
        out_ready = 1'b1;
        for (int dd = 0; dd < 2; dd++) begin
            check({name, ".done_seen"}, (done_k[dd] >= 0), 1);
            check({name, ".count"}, 32'(got_n[dd]), 32'(n[dd]));
            for (int p = 0; p < n[dd] && p < got_n[dd]; p++) begin
                check({name, ".addr"}, 32'(got_addr[dd][p]), 32'(exp_addr[dd][p]));
                check({name, ".data"}, 32'(got_data[dd][p]), 32'(exp_data[dd][p]));
                check({name, ".group_end"}, 32'(got_ge[dd][p]), 32'(exp_ge[dd][p]));
                check({name, ".last"}, 32'(got_last[dd][p]), 32'(exp_last[dd][p]));
            end
            if (n[dd] > 0) begin
                check({name, ".first_latency"}, 32'(first_k[dd]), 32'd1);
                if (mode == 0) check({name, ".done_time"}, 32'(done_k[dd]), 32'(n[dd] + g[dd]));
            end else begin
                check({name, ".no_valid"}, 32'(first_k[dd]), 32'hFFFF_FFFF);
                check({name, ".done_time0"}, 32'(done_k[dd]), 32'd0);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        for (int dd = 0; dd < 2; dd++) begin
            check({name, ".out_valid"}, ov[dd], 0);
            check({name, ".out_addr"}, oa[dd], 0);
            check({name, ".out_data"}, od[dd], 0);
            check({name, ".group_end"}, oge[dd], 0);
            check({name, ".last"}, olast[dd], 0);
            check({name, ".busy"}, obusy[dd], 0);
            check({name, ".done"}, odone[dd], 0);
            check({name, ".in_ready"}, in_ready[dd], 1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        in_data = 16'h0000; in_count = 3'd0;
        repeat (2) @(posedge clk_mj);
        @(negedge clk_mj);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Elements {3,-2,7,3}: both instances, then fixed expected orders.
        run_batch("basic", 16'h37E3, 4, 0, 0);
        check("basic.ds_addr", {got_addr[0][0][1:0], got_addr[0][1][1:0], got_addr[0][2][1:0], got_addr[0][3][1:0]},
              {2'd2, 2'd0, 2'd3, 2'd1});
        check("basic.ds_data", {got_data[0][0][3:0], got_data[0][1][3:0], got_data[0][2][3:0], got_data[0][3][3:0]},
              {4'd7, 4'd3, 4'd3, 4'hE});
        check("basic.ds_ge", {got_ge[0][0][0], got_ge[0][1][0], got_ge[0][2][0], got_ge[0][3][0]}, 4'b1011);
        check("basic.au_addr", {got_addr[1][0][1:0], got_addr[1][1][1:0], got_addr[1][2][1:0], got_addr[1][3][1:0]},
              {2'd0, 2'd3, 2'd2, 2'd1});
        check("basic.au_data", {got_data[1][0][3:0], got_data[1][1][3:0], got_data[1][2][3:0], got_data[1][3][3:0]},
              {4'd3, 4'd3, 4'd7, 4'd14});

        run_batch("equal", 16'h5555, 4, 0, 0);
        check("equal.ge_only_last", {got_ge[0][0][0], got_ge[0][1][0], got_ge[0][2][0], got_ge[0][3][0]}, 4'b0001);
        run_batch("count2", 16'hFF19, 2, 0, 0);
        run_batch("count0", 16'h1234, 0, 0, 0);
        run_batch("clamp", 16'hA0C3, 7, 0, 0);
        run_batch("stall_eq", 16'h5555, 4, 1, 2);
        run_batch("stall_mix", 16'h37E3, 4, 1, 1);

        // Abort in the second emit cycle while a handshake is also offered.
        @(negedge clk_mj);
        in_valid = 1'b1; in_data = 16'h5555; in_count = 3'd4; out_ready = 1'b1;
        @(negedge clk_mj);
        in_valid = 1'b0;
        @(negedge clk_mj);
        @(negedge clk_mj);
        check("abort.pre_valid0", ov[0], 1);
        check("abort.pre_valid1", ov[1], 1);
        abort = 1'b1;
        @(negedge clk_mj);
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_idle_outputs("abort");
            @(negedge clk_mj);
        end

        // Synchronous reset in the middle of a batch, then a fresh batch.
        in_valid = 1'b1; in_data = 16'h37E3; in_count = 3'd4;
        @(negedge clk_mj);
        in_valid = 1'b0;
        @(negedge clk_mj);
        @(negedge clk_mj);
        check("rst.pre_busy", obusy[0], 1);
        rst = 1'b1;
        abort = 1'b1;
        @(negedge clk_mj);
        check_idle_outputs("midrst");
        rst = 1'b0;
        abort = 1'b0;
        run_batch("after_rst", 16'h37E3, 4, 0, 0);

        for (int t = 0; t < 24; t++) begin
            run_batch("rand", 16'($urandom), $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(1, 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sort_engine_param.md
SORT_ENGINE_PARAM -- requirements
Module: sort_engine_param

Interface
REQ-001 SHALL have parameter ELEMENT_NUM, default 8: number of elements per batch, at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per element, at least 2.
REQ-003 SHALL have parameter DESCEND, default 1: 1 emits largest first, 0 emits smallest first.
REQ-004 SHALL have parameter SIGNED, default 1: 1 treats elements as two's complement, 0 as unsigned.
REQ-005 SHALL define AW = $clog2(ELEMENT_NUM) and CW = $clog2(ELEMENT_NUM+1).
REQ-006 SHALL have the following ports, clock and reset first:
- clk_mj  in  1: single clock.
- rst  in  1: synchronous reset, active-high.
- in_valid  in  1: batch offered.
- in_ready  out  1: batch can be accepted.
- in_data  in  ELEMENT_NUM*DATA_WIDTH: element i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- in_count  in  CW: elements 0..in_count-1 are valid.
- abort  in  1: discard the current batch.
- out_valid  out  1: sorted element presented.
- out_ready  in  1: sink accepts.
- out_addr  out  AW: index of the emitted element.
- out_data  out  DATA_WIDTH: value of the emitted element.
- out_group_end  out  1: last element of an equal-value group.
- out_last  out  1: last element of the batch.
- busy  out  1: state is not IDLE.
- done  out  1: one-cycle pulse when a batch completes.

Function
REQ-007 SHALL implement states IDLE, EVAL, EMIT, DONE; in_ready = 1 only in IDLE.
REQ-008 In IDLE, in_valid&in_ready SHALL register in_data, set EVT[i] = (i < in_count), and go to EVAL. If in_count = 0 it SHALL go to DONE instead.
REQ-009 in_count > ELEMENT_NUM SHALL be clamped to ELEMENT_NUM.
REQ-010 EVAL SHALL compute the filter output comparison-free, bit-serially from MSB to LSB.
- Start with cand = EVT.
- Per bit: sel = cand & key_bit. For DESCEND=0, use sel = cand & ~key_bit.
- cand = (sel != 0) ? sel : cand.
- When SIGNED=1, key_bit at the MSB SHALL be the inverted MSB.
REQ-011 EVAL SHALL register the final cand into FO_reg and enter EMIT on the next edge; EVAL lasts exactly one cycle.
REQ-012 In EMIT, out_valid SHALL be 1; out_addr SHALL be the lowest set index of FO_reg, and out_data SHALL be that element's stored value.
REQ-013 On out_valid&out_ready, that bit SHALL be cleared in both FO_reg and EVT.
- If EVT becomes 0, go to DONE.
- Else if FO_reg becomes 0, go to EVAL.
- Else stay in EMIT.
REQ-014 When out_ready = 0, out_addr, out_data, out_group_end and out_last SHALL hold stable.
REQ-015 out_group_end SHALL be 1 when FO_reg has exactly one bit set; out_last SHALL be 1 when EVT has exactly one bit set.
REQ-016 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-017 Latency: a batch accepted at edge T SHALL give first out_valid at T+2. Each group boundary costs exactly one bubble cycle (EVAL). Equal values SHALL be emitted in ascending index order with no bubbles.
REQ-018 abort SHALL be honoured in any state other than IDLE. On the next edge the block goes to IDLE, clears EVT and FO_reg, and does not pulse done.
REQ-019 abort SHALL take priority over a handshake in the same cycle.

Reset
REQ-020 On rst the block SHALL enter IDLE and clear EVT, FO_reg and the data registers.
REQ-021 Out of reset, outputs SHALL be out_valid=0, out_addr=0, out_data=0, out_group_end=0, out_last=0, busy=0, done=0 and in_ready=1.
REQ-022 rst SHALL override abort and all handshakes, including in the middle of a batch.

Structure
REQ-023 A shared package sort_pkg SHALL hold the state enum and the default values of ELEMENT_NUM, DATA_WIDTH, DESCEND and SIGNED.
REQ-024 One sub-module, sort_lsb_enc, SHALL be used: combinational, parametrised by ELEMENT_NUM.
- Inputs: the FO_reg vector.
- Outputs: the lowest set index, any, and onehot-exactly-one.
- It is instantiated for both FO_reg and EVT.
REQ-025 Implementation SHALL have no combinational path from in_* or out_ready to out_valid, out_addr or out_data.

Verification
REQ-026 N=4, W=4, signed, descending; in_data elements {3,-2,7,3}, in_count=4; out_ready=1.
- Emits addr 2,0,3,1 and data 7,3,3,-2.
- out_group_end = 1,0,1,1; out_last only on addr 1.
- done pulses one cycle after the last element.
REQ-027 Same data with DESCEND=0 and SIGNED=0.
- Emits addr 0,3,2,1 and data 3,3,7,14 (-2 read as unsigned is 14).
REQ-028 All elements equal to 5, in_count=4.
- Emits addr 0,1,2,3 on consecutive cycles with no bubble.
- out_group_end only on addr 3.
REQ-029 in_count=2 with elements {9,1,15,15}: emits only addr 0 then 1.
REQ-029a in_count=0: done pulses at T+1 and out_valid is never asserted.
REQ-030 Backpressure: out_ready low for 3 cycles in the middle of a group.
- Outputs hold stable; order is unchanged.
REQ-030a abort asserted during the second EMIT: out_valid drops next cycle, no done, in_ready returns to 1.
REQ-031 rst asserted mid-batch: all outputs return to their reset values on the next edge.
- A new batch then sorts correctly.
